keypad_disp_ctrl: RTL
=====================

KEYPAD_DISP_CTRL -- requirements
Module: keypad_disp_ctrl

Interface
REQ-001 SHALL have parameter KEY_ROWS, default 4: number of driven keypad rows (2..4).
REQ-002 SHALL have parameter KEY_COLS, default 4: number of sensed keypad columns (2..4).
REQ-003 SHALL have parameter DIGITS, default 4: number of multiplexed 7-segment digits (1..8).
REQ-004 SHALL have parameter SCAN_DIV, default 50000: clocks per scan/sample step (>=2).
REQ-005 SHALL have parameter DEBOUNCE, default 4: consecutive stable samples required (1..15).
REQ-006 SHALL have parameter REFRESH_DIV, default 50000: clocks per display digit slot (>=2).
REQ-007 SHALL have port clk, input, 1: single system clock; all logic on posedge.
REQ-008 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port key_in, input, KEY_COLS: column sense, active-low, pulled up.
REQ-010 SHALL have port key_out, output, KEY_ROWS: row drive, exactly one bit low.
REQ-011 SHALL have port key_valid, output, 1: one-cycle pulse per accepted key press.
REQ-012 SHALL have port key_code, output, 4: code of last accepted key (row*KEY_COLS+col).
REQ-013 SHALL have port seg, output, 7: segments {g,f,e,d,c,b,a}, active-high.
REQ-014 SHALL have port seg_en, output, DIGITS: digit enables, active-low, at most one low.

Function
REQ-015 SHALL pass key_in through a 2-flop synchroniser (reset value all ones) before any use.
REQ-016 SHALL implement scanner FSM states SCAN, DEB_PRESS, PRESSED, DEB_REL; all sampling on a SCAN_DIV tick.
REQ-017 SCAN SHALL rotate the low key_out bit row 0 -> KEY_ROWS-1 -> row 0 each tick; any synchronised column low at a tick -> DEB_PRESS with row held.
REQ-018 DEB_PRESS SHALL hold the row; DEBOUNCE consecutive ticks with an identical non-all-ones column pattern -> PRESSED; any all-ones sample -> SCAN, nothing reported; a differing non-all-ones pattern restarts the count with the new pattern.
REQ-019 On entry to PRESSED SHALL pulse key_valid for exactly one clock and load key_code; multiple low columns resolve to the lowest column index.
REQ-020 PRESSED SHALL hold the row until a sample is all ones -> DEB_REL; keys in other rows SHALL be ignored.
REQ-021 DEB_REL SHALL require DEBOUNCE consecutive all-ones samples -> SCAN resuming at the next row; any low sample -> PRESSED without a new key_valid.
REQ-022 SHALL keep a DIGITS-entry buffer of 4-bit codes, entry 0 rightmost; value 4'hF = blank.
REQ-023 On key_valid, the buffer SHALL update on the following clock: code 0..9 shifts left, new code in entry 0, entry DIGITS-1 dropped; code 10 (backspace) shifts right, blank into top entry; code 11 (clear) sets all blank; codes 12..15 leave the buffer unchanged.
REQ-024 Backspace or clear on an all-blank buffer SHALL leave it unchanged; a digit on a full buffer SHALL drop the oldest digit silently.
REQ-025 Display SHALL step digit index 0..DIGITS-1 and wrap, one step per REFRESH_DIV clocks; seg_en bit index low, all others high.
REQ-026 seg SHALL be registered and decode the indexed entry: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex), blank or other code = 00; seg and seg_en change on the same clock.
REQ-027 Scanner and display SHALL run concurrently; a buffer update mid-slot SHALL appear no later than the next slot boundary.

Reset
REQ-028 While rst_n low SHALL force: key_out row 0 low others high, key_valid 0, key_code 0, seg 0, seg_en all ones, buffer all blank, FSM SCAN, all counters 0.
REQ-029 Reset asserted mid-debounce or mid-press SHALL discard the press; no key_valid after release of reset until a fresh full debounce.

Verification (bench params SCAN_DIV=4, DEBOUNCE=3, REFRESH_DIV=8, DIGITS=4, 4x4 keypad)
REQ-030 Press row1/col2, held 40 clocks -> exactly one key_valid, key_code=6; buffer {F,F,F,6}; slot 0 seg=7D, slots 1..3 seg=00.
REQ-031 Bounce: column low 1 tick, high 1 tick, then low steady -> single key_valid only after 3 consecutive stable ticks.
REQ-032 Enter 1,2,3,4,5 -> buffer {2,3,4,5}; then code 10 -> {F,2,3,4}; then code 11 -> all blank, seg=00 in every slot.
REQ-033 Row1 cols 0 and 3 pressed together -> key_code=4; simultaneous row2 press ignored until release debounce completes.
REQ-034 rst_n pulsed low during DEB_PRESS -> no key_valid; outputs equal REQ-028 values within the reset cycle.
REQ-035 Idle 64 clocks -> seg_en cycles 1110,1101,1011,0111 each 8 clocks; key_out low bit rotates every 4 clocks.

Source files
------------

// File: rtl/keypad_disp_ctrl.sv
// keypad_disp_ctrl: row-scanned, debounced matrix keypad feeding a digit-entry
// buffer that is shown on a multiplexed common 7-segment display.
module keypad_disp_ctrl #(
  parameter int KEY_ROWS    = 4,
  parameter int KEY_COLS    = 4,
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int DEBOUNCE    = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEY_COLS-1:0] key_in,
  output logic [KEY_ROWS-1:0] key_out,
  output logic                key_valid,
  output logic [3:0]          key_code,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   seg_en
);
  localparam int SCW = $clog2(SCAN_DIV);
  localparam int RFW = $clog2(REFRESH_DIV);
  localparam int RW  = $clog2(KEY_ROWS);
  localparam int CW  = $clog2(KEY_COLS);
  localparam int DW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_REL} state_t;

  logic [KEY_COLS-1:0] r_sync1, r_sync2;
  logic [SCW-1:0]      r_scan_cnt;
  logic                w_scan_tick;
  state_t              r_state, w_state_next;
  logic [RW-1:0]       r_row, w_row_next, w_row_inc;
  logic [KEY_COLS-1:0] r_pat, w_pat_next;
  logic [3:0]          r_deb_cnt, w_deb_cnt_next, w_run;
  logic                w_all_high, w_accept;
  logic [CW-1:0]       w_col;
  logic [3:0]          w_code;
  logic                r_key_valid;
  logic [3:0]          r_key_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_scan_tick = (r_scan_cnt == SCW'(SCAN_DIV - 1));
  assign w_all_high  = &r_sync2;
  assign w_row_inc   = (r_row == RW'(KEY_ROWS - 1)) ? '0 : r_row + 1'b1;
  assign w_run       = (r_deb_cnt != 4'd0 && r_sync2 == r_pat) ? r_deb_cnt + 4'd1 : 4'd1;

  // Lowest-index low column wins when several columns in the row are pressed.
  always_comb begin
    w_col = '0;
    for (int c = KEY_COLS - 1; c >= 0; c--) begin
      if (!r_sync2[c]) w_col = CW'(c);
    end
  end

  assign w_code = 4'(r_row) * 4'(KEY_COLS) + 4'(w_col);

  always_comb begin
    w_state_next   = r_state;
    w_row_next     = r_row;
    w_pat_next     = r_pat;
    w_deb_cnt_next = r_deb_cnt;
    w_accept       = 1'b0;
    if (w_scan_tick) begin
      case (r_state)
        SCAN: begin
          if (!w_all_high) begin
            w_state_next   = DEB_PRESS;
            w_deb_cnt_next = 4'd0;
          end else begin
            w_row_next = w_row_inc;
          end
        end
        DEB_PRESS: begin
          // A run counts only ticks taken while holding the row in this state.
          if (w_all_high) begin
            w_state_next   = SCAN;
            w_deb_cnt_next = 4'd0;
          end else if (w_run == 4'(DEBOUNCE)) begin
            w_state_next   = PRESSED;
            w_pat_next     = r_sync2;
            w_deb_cnt_next = 4'd0;
            w_accept       = 1'b1;
          end else begin
            w_pat_next     = r_sync2;
            w_deb_cnt_next = w_run;
          end
        end
        PRESSED: begin
          if (w_all_high) begin
            w_state_next   = DEB_REL;
            w_deb_cnt_next = 4'd0;
          end
        end
        DEB_REL: begin
          if (!w_all_high) begin
            w_state_next   = PRESSED;
            w_deb_cnt_next = 4'd0;
          end else if (r_deb_cnt + 4'd1 == 4'(DEBOUNCE)) begin
            w_state_next   = SCAN;
            w_row_next     = w_row_inc;
            w_deb_cnt_next = 4'd0;
          end else begin
            w_deb_cnt_next = r_deb_cnt + 4'd1;
          end
        end
        default: w_state_next = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt  <= '0;
      r_state     <= SCAN;
      r_row       <= '0;
      r_pat       <= '1;
      r_deb_cnt   <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'd0;
    end else begin
      r_scan_cnt  <= w_scan_tick ? '0 : r_scan_cnt + 1'b1;
      r_state     <= w_state_next;
      r_row       <= w_row_next;
      r_pat       <= w_pat_next;
      r_deb_cnt   <= w_deb_cnt_next;
      r_key_valid <= w_accept;
      if (w_accept) r_key_code <= w_code;
    end
  end

  assign key_out   = ~(KEY_ROWS'(1) << r_row);
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;

  // Entry buffer: entry 0 is the rightmost digit, 4'hF marks a blank.
  logic [3:0] r_buf      [DIGITS];
  logic [3:0] w_buf_next [DIGITS];

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_buf
    logic [3:0] w_lower, w_upper;
    if (gi == 0) begin : g_bot
      assign w_lower = r_key_code;
    end else begin : g_mid
      assign w_lower = r_buf[gi-1];
    end
    if (gi == DIGITS - 1) begin : g_top
      assign w_upper = 4'hF;
    end else begin : g_low
      assign w_upper = r_buf[gi+1];
    end
    assign w_buf_next[gi] = (r_key_code <= 4'd9)  ? w_lower :
                            (r_key_code == 4'd10) ? w_upper :
                            (r_key_code == 4'd11) ? 4'hF    : r_buf[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) r_buf[i] <= 4'hF;
    end else if (r_key_valid) begin
      for (int i = 0; i < DIGITS; i++) r_buf[i] <= w_buf_next[i];
    end
  end

  logic [RFW-1:0]    r_ref_cnt;
  logic              w_ref_tick;
  logic [DW-1:0]     r_digit;
  logic [3:0]        w_cur;
  logic [6:0]        w_seg_dec;
  logic [6:0]        r_seg;
  logic [DIGITS-1:0] r_seg_en;

  assign w_ref_tick = (r_ref_cnt == RFW'(REFRESH_DIV - 1));
  assign w_cur      = r_buf[r_digit];

  always_comb begin
    w_seg_dec = 7'h00;
    case (w_cur)
      4'd0: w_seg_dec = 7'h3F;
      4'd1: w_seg_dec = 7'h06;
      4'd2: w_seg_dec = 7'h5B;
      4'd3: w_seg_dec = 7'h4F;
      4'd4: w_seg_dec = 7'h66;
      4'd5: w_seg_dec = 7'h6D;
      4'd6: w_seg_dec = 7'h7D;
      4'd7: w_seg_dec = 7'h07;
      4'd8: w_seg_dec = 7'h7F;
      4'd9: w_seg_dec = 7'h6F;
      default: w_seg_dec = 7'h00;
    endcase
  end

  // Segments and enable latch together at each slot boundary, so a buffer
  // change mid-slot shows up at the next boundary without tearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_cnt <= '0;
      r_digit   <= '0;
      r_seg     <= 7'h00;
      r_seg_en  <= '1;
    end else begin
      r_ref_cnt <= w_ref_tick ? '0 : r_ref_cnt + 1'b1;
      if (w_ref_tick) begin
        r_seg    <= w_seg_dec;
        r_seg_en <= ~(DIGITS'(1) << r_digit);
        r_digit  <= (r_digit == DW'(DIGITS - 1)) ? '0 : r_digit + 1'b1;
      end
    end
  end

  assign seg    = r_seg;
  assign seg_en = r_seg_en;

endmodule
